// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and saturation constants for addsub_serial
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] sat_const(input int w, input logic neg);
        logic [MAX_W-1:0] one;
        logic [MAX_W-1:0] msb;
        one = MAX_W'(1);
        msb = one << (w - 1);
        return neg ? msb : msb - one;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result valid-ready bundle for addsub_serial
interface addsub_serial_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry, ovf, zero
    );

endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder slice exposing the carry into its MSB
module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_top_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout     = c[CHUNK];
        c_top_in = c[CHUNK-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: chunk-serial add/sub with carry/ovf/zero flags; ADDSUB_SERIAL_SAT_EN enables saturation
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic           clk,
    input logic           rst_n,
    addsub_serial_if.slave bus
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    generate
        if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t                 state;
    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-1:0]       acc;
    logic [WIDTH-1:0]       res;
    logic [CW-1:0]          cnt;
    logic                   cy;
    logic                   carry_q;
    logic                   ovf_q;
    logic                   zero_q;
    logic [CHUNK-1:0]       s;
    logic                   cout;
    logic                   c_top;
    logic [WIDTH+CHUNK-1:0] cat;
    logic [WIDTH-1:0]       fin;
    logic                   last;
    logic                   ovf_n;

`ifdef ADDSUB_SERIAL_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_const(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_const(WIDTH, 1'b1));
    logic a_sign;
`endif

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x        (a_sh[CHUNK-1:0]),
        .y        (b_sh[CHUNK-1:0]),
        .cin      (cy),
        .s        (s),
        .cout     (cout),
        .c_top_in (c_top)
    );

    // New chunks enter from the MSB so the result is aligned after NCH shifts
    always_comb begin
        cat   = {s, acc};
        last  = cnt == CW'(NCH - 1);
        ovf_n = c_top ^ cout;
`ifdef ADDSUB_SERIAL_SAT_EN
        fin   = ovf_n ? (a_sign ? SAT_NEG : SAT_POS) : cat[WIDTH+CHUNK-1:CHUNK];
`else
        fin   = cat[WIDTH+CHUNK-1:CHUNK];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            res     <= '0;
            cnt     <= '0;
            cy      <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef ADDSUB_SERIAL_SAT_EN
            a_sign  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh   <= bus.a;
                    b_sh   <= bus.b ^ {WIDTH{bus.sub}};
                    cy     <= bus.sub;
                    cnt    <= '0;
                    state  <= RUN;
`ifdef ADDSUB_SERIAL_SAT_EN
                    a_sign <= bus.a[WIDTH-1];
`endif
                end
                RUN: begin
                    a_sh <= a_sh >> CHUNK;
                    b_sh <= b_sh >> CHUNK;
                    acc  <= cat[WIDTH+CHUNK-1:CHUNK];
                    cy   <= cout;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        res     <= fin;
                        carry_q <= cout;
                        ovf_q   <= ovf_n;
                        zero_q  <= ~|fin;
                        state   <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.result    = res;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vectors for addsub_serial at WIDTH=8, CHUNK=2
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(8)) bus ();

    addsub_serial #(.WIDTH(8), .CHUNK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef ADDSUB_SERIAL_SAT_EN
    localparam logic [7:0] R_POS_OVF = 8'h7F;
    localparam logic [7:0] R_NEG_OVF = 8'h80;
`else
    localparam logic [7:0] R_POS_OVF = 8'h80;
    localparam logic [7:0] R_NEG_OVF = 8'h7F;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] er, input logic ec, input logic eo, input logic ez,
                      input int hold);
        int n;
        chk("in_ready_idle", bus.in_ready, 1);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 8'hA5;
        bus.b = 8'h5A;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 4);
        chk("result", bus.result, er);
        chk("carry", bus.carry, ec);
        chk("ovf", bus.ovf, eo);
        chk("zero", bus.zero, ez);
        chk("in_ready_done", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_result", bus.result, er);
            chk("hold_flags", {bus.carry, bus.ovf, bus.zero}, {ec, eo, ez});
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.carry, bus.ovf, bus.zero}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        op(8'h7F, 8'h01, 1'b0, R_POS_OVF, 1'b0, 1'b1, 1'b0, 0);
        op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 3);
        op(8'h80, 8'h01, 1'b1, R_NEG_OVF, 1'b1, 1'b1, 1'b0, 0);
        // Abort an operation after its second chunk; outputs must clear at once
        bus.a = 8'h55;
        bus.b = 8'h33;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_flags", {bus.carry, bus.ovf, bus.zero}, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_rel_in_ready", bus.in_ready, 1);
        op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
